// File: rtl/mips_exec_mem_unit.sv
// Control decode, ALU and 1024-word data memory slice of the single-cycle MIPS-Lite3 core.
// Latency: decode and ALU are combinational; DM read is combinational, DM write lands on the core_clk rising edge.
// Backpressure: none, every instruction completes in one cycle.
//
// Ports:
//   core_clk, arst_n   clock; asynchronous active-low reset that clears the whole DM
//   op, func           instruction fields Instr[31:26] and Instr[5:0]
//   rs_data, rt_data   GPR read ports (ALU A, ALU B / store data)
//   imm_ext            extended immediate (ALU B when Alusrc=1)
//   Regdst..Aluop      datapath control to the surrounding core
//   alu_c, Zero        ALU result and its zero flag
//   dm_out             DM read data at address alu_c[11:2]
module mips_exec_mem_unit #(
  parameter int DM_WORDS = 1024
) (
  input  logic        core_clk,
  input  logic        arst_n,
  input  logic [5:0]  op,
  input  logic [5:0]  func,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] imm_ext,
  output logic [1:0]  Regdst,
  output logic        Regwrite,
  output logic [1:0]  Memtoreg,
  output logic [1:0]  nPC_sel,
  output logic        Extop,
  output logic        Alusrc,
  output logic        Memwrite,
  output logic [2:0]  Aluop,
  output logic [31:0] alu_c,
  output logic        Zero,
  output logic [31:0] dm_out
);

  localparam int AW = $clog2(DM_WORDS);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_LUI = 3'b100;

  // ---------------------------------------------------------------------------
  // Decode: everything defaults to 0 so undefined encodings become a NOP and
  // can never write the GPR or the DM.
  // ---------------------------------------------------------------------------
  always_comb begin
    Regdst   = 2'b00;
    Regwrite = 1'b0;
    Memtoreg = 2'b00;
    nPC_sel  = 2'b00;
    Extop    = 1'b0;
    Alusrc   = 1'b0;
    Memwrite = 1'b0;
    Aluop    = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADDU: begin
            Regdst   = 2'b01;
            Regwrite = 1'b1;
            Aluop    = ALU_ADD;
          end
          FN_SUBU: begin
            Regdst   = 2'b01;
            Regwrite = 1'b1;
            Aluop    = ALU_SUB;
          end
          FN_SLT: begin
            Regdst   = 2'b01;
            Regwrite = 1'b1;
            Aluop    = ALU_SLT;
          end
          FN_JR: begin
            nPC_sel = 2'b11;
          end
          default: ;
        endcase
      end
      OP_ORI: begin
        Regwrite = 1'b1;
        Alusrc   = 1'b1;
        Aluop    = ALU_OR;
      end
      OP_ADDI, OP_ADDIU: begin
        // No overflow trap: addi behaves exactly like addiu.
        Regwrite = 1'b1;
        Extop    = 1'b1;
        Alusrc   = 1'b1;
        Aluop    = ALU_ADD;
      end
      OP_LUI: begin
        Regwrite = 1'b1;
        Alusrc   = 1'b1;
        Aluop    = ALU_LUI;
      end
      OP_LW: begin
        Regwrite = 1'b1;
        Memtoreg = 2'b01;
        Extop    = 1'b1;
        Alusrc   = 1'b1;
        Aluop    = ALU_ADD;
      end
      OP_SW: begin
        Extop    = 1'b1;
        Alusrc   = 1'b1;
        Memwrite = 1'b1;
        Aluop    = ALU_ADD;
      end
      OP_BEQ: begin
        nPC_sel = 2'b01;
        Aluop   = ALU_SUB;
      end
      OP_J: begin
        nPC_sel = 2'b10;
      end
      OP_JAL: begin
        Regdst   = 2'b10;
        Regwrite = 1'b1;
        Memtoreg = 2'b10;
        nPC_sel  = 2'b10;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [31:0] alu_b;

  always_comb begin
    alu_b = Alusrc ? imm_ext : rt_data;
    alu_c = 32'h0;
    case (Aluop)
      ALU_ADD: alu_c = rs_data + alu_b;
      ALU_SUB: alu_c = rs_data - alu_b;
      ALU_OR:  alu_c = rs_data | alu_b;
      ALU_SLT: alu_c = {31'h0, $signed(rs_data) < $signed(alu_b)};
      ALU_LUI: alu_c = {alu_b[15:0], 16'h0};
      default: alu_c = 32'h0;
    endcase
  end

  assign Zero = (alu_c == 32'h0);

  // ---------------------------------------------------------------------------
  // Data memory: word addressed, byte offset and upper address bits ignored.
  // The whole array sits under the async reset so a reset pulse wipes every
  // word at once and also wins over a store in the same cycle.
  // ---------------------------------------------------------------------------
  logic [31:0]   mem [DM_WORDS];
  logic [AW-1:0] dm_addr;

  assign dm_addr = alu_c[AW+1:2];
  assign dm_out  = mem[dm_addr];

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DM_WORDS; i++) begin
        mem[i] <= 32'h0;
      end
    end else if (Memwrite) begin
      mem[dm_addr] <= rt_data;
    end
  end

endmodule

// File: tb/tb_mips_exec_mem_unit.sv
// Directed bench for mips_exec_mem_unit: expected values are queued as each
// step is driven and popped in order when the DUT outputs are sampled.
module tb_mips_exec_mem_unit;

  logic        core_clk = 1'b0;
  logic        arst_n;
  logic [5:0]  op;
  logic [5:0]  func;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] imm_ext;
  logic [1:0]  Regdst;
  logic        Regwrite;
  logic [1:0]  Memtoreg;
  logic [1:0]  nPC_sel;
  logic        Extop;
  logic        Alusrc;
  logic        Memwrite;
  logic [2:0]  Aluop;
  logic [31:0] alu_c;
  logic        Zero;
  logic [31:0] dm_out;

  mips_exec_mem_unit #(.DM_WORDS(1024)) dut (
    .core_clk (core_clk),
    .arst_n   (arst_n),
    .op       (op),
    .func     (func),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .imm_ext  (imm_ext),
    .Regdst   (Regdst),
    .Regwrite (Regwrite),
    .Memtoreg (Memtoreg),
    .nPC_sel  (nPC_sel),
    .Extop    (Extop),
    .Alusrc   (Alusrc),
    .Memwrite (Memwrite),
    .Aluop    (Aluop),
    .alu_c    (alu_c),
    .Zero     (Zero),
    .dm_out   (dm_out)
  );

  always #5 core_clk = ~core_clk;

  localparam logic [5:0] RT    = 6'b000000;
  localparam logic [5:0] ORI   = 6'b001101;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] ADDIU = 6'b001001;
  localparam logic [5:0] LUI   = 6'b001111;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] J     = 6'b000010;
  localparam logic [5:0] JAL   = 6'b000011;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Expected control word, packed Regdst,Regwrite,Memtoreg,nPC_sel,Extop,Alusrc,Memwrite,Aluop.
  function automatic logic [31:0] cw(input logic [1:0] rd, input logic rw, input logic [1:0] mr,
                                     input logic [1:0] np, input logic eo, input logic as,
                                     input logic mw, input logic [2:0] ao);
    return {19'h0, rd, rw, mr, np, eo, as, mw, ao};
  endfunction

  function automatic logic [31:0] ctl_obs();
    return {19'h0, Regdst, Regwrite, Memtoreg, nPC_sel, Extop, Alusrc, Memwrite, Aluop};
  endfunction

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_underflow observed=%h expected=<none>", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // Drive one instruction on the falling edge, then let the comb paths settle.
  task automatic drive(input logic [5:0] o, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm);
    @(negedge core_clk);
    op      = o;
    func    = f;
    rs_data = a;
    rt_data = b;
    imm_ext = imm;
    #1;
  endtask

  initial begin
    arst_n  = 1'b0;
    op      = 6'h0;
    func    = 6'h0;
    rs_data = 32'h0;
    rt_data = 32'h0;
    imm_ext = 32'h0;
    #1;
    push("reset_dm_out", 32'h0);
    pop_check(dm_out);
    @(negedge core_clk);
    arst_n = 1'b1;

    // Fresh memory reads zero at low, middle and top words.
    drive(LW, 6'h0, 32'h0, 32'h0, 32'h0);
    push("lw_ctl", cw(2'b00, 1, 2'b01, 2'b00, 1, 1, 0, 3'b000));
    push("lw_dm0", 32'h0);
    pop_check(ctl_obs());
    pop_check(dm_out);
    drive(LW, 6'h0, 32'h0, 32'h0, 32'h800);
    push("lw_dm512", 32'h0);
    pop_check(dm_out);
    drive(LW, 6'h0, 32'h0, 32'h0, 32'hFFC);
    push("lw_dm1023", 32'h0);
    pop_check(dm_out);

    // Store then load back; the new word must not appear before the edge.
    drive(SW, 6'h0, 32'h10, 32'hDEADBEEF, 32'h4);
    push("sw_ctl", cw(2'b00, 0, 2'b00, 2'b00, 1, 1, 1, 3'b000));
    push("sw_alu_c", 32'h14);
    push("sw_dm_before_edge", 32'h0);
    pop_check(ctl_obs());
    pop_check(alu_c);
    pop_check(dm_out);
    @(posedge core_clk);
    #1;
    push("sw_dm_after_edge", 32'hDEADBEEF);
    pop_check(dm_out);
    drive(LW, 6'h0, 32'h10, 32'h0, 32'h4);
    push("lw_back_alu_c", 32'h14);
    push("lw_back_dm", 32'hDEADBEEF);
    pop_check(alu_c);
    pop_check(dm_out);
    drive(LW, 6'h0, 32'h10, 32'h0, 32'h7);
    push("lw_byte_offset_ignored", 32'hDEADBEEF);
    pop_check(dm_out);
    drive(LW, 6'h0, 32'h10, 32'h0, 32'h1004);
    push("lw_upper_bits_ignored", 32'hDEADBEEF);
    pop_check(dm_out);

    // R-type arithmetic.
    drive(RT, 6'b100011, 32'h7, 32'h7, 32'hFFFF);
    push("subu_ctl", cw(2'b01, 1, 2'b00, 2'b00, 0, 0, 0, 3'b001));
    push("subu_alu_c", 32'h0);
    push("subu_zero", 32'h1);
    pop_check(ctl_obs());
    pop_check(alu_c);
    pop_check({31'h0, Zero});
    drive(RT, 6'b100001, 32'hFFFFFFFF, 32'h1, 32'h0);
    push("addu_ctl", cw(2'b01, 1, 2'b00, 2'b00, 0, 0, 0, 3'b000));
    push("addu_wrap", 32'h0);
    push("addu_zero", 32'h1);
    pop_check(ctl_obs());
    pop_check(alu_c);
    pop_check({31'h0, Zero});
    drive(RT, 6'b101010, 32'hFFFFFFFF, 32'h1, 32'h0);
    push("slt_ctl", cw(2'b01, 1, 2'b00, 2'b00, 0, 0, 0, 3'b011));
    push("slt_neg_lt_pos", 32'h1);
    pop_check(ctl_obs());
    pop_check(alu_c);
    drive(RT, 6'b101010, 32'h1, 32'hFFFFFFFF, 32'h0);
    push("slt_pos_lt_neg", 32'h0);
    push("slt_zero_flag", 32'h1);
    pop_check(alu_c);
    pop_check({31'h0, Zero});

    // Branch compare.
    drive(BEQ, 6'h0, 32'h5, 32'h5, 32'h0);
    push("beq_ctl", cw(2'b00, 0, 2'b00, 2'b01, 0, 0, 0, 3'b001));
    push("beq_equal_zero", 32'h1);
    pop_check(ctl_obs());
    pop_check({31'h0, Zero});
    drive(BEQ, 6'h0, 32'h5, 32'h6, 32'h0);
    push("beq_ne_alu_c", 32'hFFFFFFFF);
    push("beq_ne_zero", 32'h0);
    pop_check(alu_c);
    pop_check({31'h0, Zero});

    // Immediate forms.
    drive(ORI, 6'h0, 32'hF0, 32'h0, 32'h0F);
    push("ori_ctl", cw(2'b00, 1, 2'b00, 2'b00, 0, 1, 0, 3'b010));
    push("ori_alu_c", 32'hFF);
    pop_check(ctl_obs());
    pop_check(alu_c);
    drive(LUI, 6'h0, 32'hAAAA5555, 32'h0, 32'h1234);
    push("lui_ctl", cw(2'b00, 1, 2'b00, 2'b00, 0, 1, 0, 3'b100));
    push("lui_alu_c", 32'h12340000);
    pop_check(ctl_obs());
    pop_check(alu_c);
    drive(ADDI, 6'h0, 32'h7FFFFFFF, 32'h0, 32'h1);
    push("addi_ctl", cw(2'b00, 1, 2'b00, 2'b00, 1, 1, 0, 3'b000));
    push("addi_wrap", 32'h80000000);
    pop_check(ctl_obs());
    pop_check(alu_c);
    drive(ADDIU, 6'h0, 32'h10, 32'h0, 32'hFFFFFFF0);
    push("addiu_ctl", cw(2'b00, 1, 2'b00, 2'b00, 1, 1, 0, 3'b000));
    push("addiu_alu_c", 32'h0);
    pop_check(ctl_obs());
    pop_check(alu_c);

    // Jumps and undefined encodings.
    drive(J, 6'h0, 32'h0, 32'h0, 32'h0);
    push("j_ctl", cw(2'b00, 0, 2'b00, 2'b10, 0, 0, 0, 3'b000));
    pop_check(ctl_obs());
    drive(JAL, 6'h0, 32'h0, 32'h0, 32'h0);
    push("jal_ctl", cw(2'b10, 1, 2'b10, 2'b10, 0, 0, 0, 3'b000));
    pop_check(ctl_obs());
    drive(RT, 6'b001000, 32'h0, 32'h0, 32'h0);
    push("jr_ctl", cw(2'b00, 0, 2'b00, 2'b11, 0, 0, 0, 3'b000));
    pop_check(ctl_obs());
    drive(6'b111111, 6'b101011, 32'h1, 32'h2, 32'h3);
    push("undef_op_ctl", 32'h0);
    pop_check(ctl_obs());
    drive(RT, 6'b100000, 32'h1, 32'h2, 32'h3);
    push("undef_func_ctl", 32'h0);
    pop_check(ctl_obs());

    // Reset colliding with a store: nothing may be written.
    @(negedge core_clk);
    op      = SW;
    func    = 6'h0;
    rs_data = 32'h0;
    rt_data = 32'h11112222;
    imm_ext = 32'h20;
    arst_n  = 1'b0;
    @(negedge core_clk);
    op     = LW;
    arst_n = 1'b1;
    #1;
    push("reset_vs_store", 32'h0);
    pop_check(dm_out);

    // Several stores, then reset mid-sequence wipes them all.
    drive(SW, 6'h0, 32'h40, 32'hA0A0A0A0, 32'h0);
    drive(SW, 6'h0, 32'h40, 32'hB1B1B1B1, 32'h4);
    drive(SW, 6'h0, 32'h40, 32'hC2C2C2C2, 32'h8);
    drive(LW, 6'h0, 32'h40, 32'h0, 32'h4);
    push("multi_store_readback", 32'hB1B1B1B1);
    pop_check(dm_out);
    drive(LW, 6'h0, 32'h40, 32'h0, 32'h0);
    push("multi_store_first", 32'hA0A0A0A0);
    pop_check(dm_out);
    arst_n = 1'b0;
    #1;
    push("reset_immediate_clear", 32'h0);
    pop_check(dm_out);
    @(negedge core_clk);
    arst_n = 1'b1;
    drive(LW, 6'h0, 32'h40, 32'h0, 32'h4);
    push("wiped_word1", 32'h0);
    pop_check(dm_out);
    drive(LW, 6'h0, 32'h40, 32'h0, 32'h8);
    push("wiped_word2", 32'h0);
    pop_check(dm_out);
    drive(LW, 6'h0, 32'h10, 32'h0, 32'h4);
    push("wiped_deadbeef", 32'h0);
    pop_check(dm_out);

    // First store after reset release must land.
    drive(SW, 6'h0, 32'h0, 32'h5A5A5A5A, 32'hFFC);
    @(posedge core_clk);
    #1;
    push("store_after_release", 32'h5A5A5A5A);
    pop_check(dm_out);

    if (exp_q.size() != 0) begin
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
